seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for the clock's multi-digit 7-segment display.
- Shares one BCD-to-segment decoder across NUM_DIGITS digit positions: selects one digit code per slot and drives the active-low digit anodes.
- Inserts blanking gaps between slots to prevent ghosting.
- Double-buffers the displayed value so a new time value never appears mid-frame.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (2..8).
- DRIVE_CYCLES, 50000, clk cycles a digit is lit per slot (>=1).
- BLANK_CYCLES, 500, clk cycles all anodes are off before each digit (>=0; 0 = no gap).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scan enable; low = display dark.
- load  in  1  one-cycle strobe: capture digitsIn into the pending buffer.
- digitsIn  in  4*NUM_DIGITS  packed BCD; [3:0] = digit 0 (rightmost, least significant).
- digitCode  out  4  registered BCD code to the decoder; 4'hF = blank.
- anode  out  NUM_DIGITS  registered, active-low digit select; bit i = digit i.
- frameStart  out  1  one-cycle pulse when the slot for digit 0 begins.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - Outputs: anode all 1s, digitCode 4'hF, frameStart 0.
  - Internal state: state BLANK, idx 0, cnt 0, active buffer all 4'hF, pending buffer all 4'hF, pendValid 0.
- FSM states:
  - BLANK: anode all 1s; digitCode = active[idx].
  - DRIVE: anode = ~(1<<idx); digitCode = active[idx].
- Transitions:
  - BLANK -> DRIVE when cnt == BLANK_CYCLES-1. If BLANK_CYCLES == 0, BLANK is skipped and the slot enters DRIVE directly.
  - DRIVE -> BLANK when cnt == DRIVE_CYCLES-1. At that point idx advances, wrapping NUM_DIGITS-1 -> 0.
  - cnt clears on every state change.
- Slot and frame length:
  - Slot = BLANK_CYCLES + DRIVE_CYCLES cycles.
  - Frame = NUM_DIGITS * slot.
  - Exactly one anode bit is low in DRIVE, none in BLANK.
- Frame boundary: the cycle in which idx wraps to 0 (or the first slot after reset / enable rise).
  - frameStart is high on the first cycle of the idx-0 slot.
  - If pendValid=1, active <= pending and pendValid <= 0.
- load handling:
  - load=1 sets pending <= digitsIn and pendValid <= 1. A later load before the boundary overwrites the earlier one (last wins).
  - load coinciding with a boundary: digitsIn is written straight into active, and pendValid is left 0.
- Update latency: a new value is visible from the first slot of the next frame, never within the current frame.
- Codes >9 are passed through unchanged; the decoder renders them blank.
- enable=0:
  - Next cycle: anode all 1s, digitCode 4'hF, frameStart 0.
  - FSM held at BLANK with idx 0 and cnt 0.
  - Loads are still accepted into pending.
  - On enable rise, a new frame starts at the digit-0 slot, with frameStart pulsed and the pending buffer committed.
- Reset mid-operation: all registers return immediately to their reset values. Pending data is discarded.

Optional Feature:
- Macro: SEVEN_SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Scanning from digit NUM_DIGITS-1 downward, each 4'h0 digit is output as 4'hF while every more-significant digit is also 0.
  - Digit 0 is never suppressed.
  - Evaluated on the active buffer, so suppression changes only at frame boundaries.
- Undefined: all digits are output verbatim.

Decomposition:
- Shared package seven_seg_pkg:
  - BLANK_CODE = 4'hF.
  - Typedef bcd_t (logic [3:0]).
  - Enum scan_state_t {BLANK, DRIVE}.
- Sub-module seven_seg_slot_timer: the cnt counter plus terminal-count compare.
  - Inputs: state, clear.
  - Output: done pulse.
  - Counter width $clog2(max(DRIVE_CYCLES, BLANK_CYCLES)+1).
- idx width is $clog2(NUM_DIGITS), with a minimum of 1.

Test Plan (NUM_DIGITS=4, DRIVE_CYCLES=8, BLANK_CYCLES=2 unless stated):
- Reset sequence: reset high, then release with enable=1 and digitsIn=16'h1234, load pulsed at the first boundary.
  - Required: anode=4'b1111 for 2 cycles, then 4'b1110 with digitCode=4 for 8 cycles.
  - Then 1111 x2, 1101/3 x8, 1011/2 x8, 0111/1 x8.
  - frameStart exactly once per 40 cycles.
- Mid-frame load: during digit 2, load 16'h5678.
  - Required: digits 2 and 3 still show 2 and 1; the next frame shows 8,7,6,5.
  - Two loads in the same frame: only the last appears.
- Load coinciding with the idx wrap: the value is visible in that very frame's digit-0 slot.
- enable dropped mid-DRIVE of digit 1:
  - Required: next cycle anode=1111 and digitCode=F, held while enable=0.
  - On re-enable: frameStart pulses, digit-0 slot restarts with 2 blank cycles.
- BLANK_CYCLES=0: anode is never 4'b1111 while enabled; each digit is lit for exactly 8 cycles.
- With SEVEN_SEG_LZ_BLANK_EN:
  - 16'h0050 -> codes F,F,5,0 for digits 3..0.
  - 16'h0000 -> F,F,F,0.
  - Without the macro: 0,0,5,0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
package seven_seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

endpackage

// File: rtl/seven_seg_slot_timer.sv
// Per-state cycle counter; o_done flags the last cycle of the current BLANK or DRIVE phase.
module seven_seg_slot_timer
    import seven_seg_pkg::*;
#(
    parameter int unsigned DRIVE_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  scan_state_t i_state,
    input  logic        i_clear,
    output logic        o_done
);

    localparam int unsigned MaxCycles = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES
                                                                       : BLANK_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam logic [CntW-1:0] DriveLast = CntW'(DRIVE_CYCLES - 1);
    // With no blanking gap the BLANK phase is never timed, so any value works.
    localparam logic [CntW-1:0] BlankLast = (BLANK_CYCLES == 0) ? '0 : CntW'(BLANK_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CntW'(1);
        end
    end

    assign o_done = (i_state == DRIVE) ? (r_cnt == DriveLast) : (r_cnt == BlankLast);

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Double-buffered multi-digit 7-segment scan controller with blanking gaps.
// Optional leading-zero suppression is enabled by defining SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DRIVE_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digitsIn,
    output logic [3:0]              digitCode,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic                    frameStart
);

    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);
    localparam scan_state_t     SlotFirst = (BLANK_CYCLES == 0) ? DRIVE : BLANK;

    scan_state_t                 r_state, w_state_d;
    logic [IdxW-1:0]             r_idx, w_idx_d;
    bcd_t [NUM_DIGITS-1:0]       r_active, w_active_d;
    bcd_t [NUM_DIGITS-1:0]       r_pending, w_pending_d;
    bcd_t [NUM_DIGITS-1:0]       w_shown;
    logic                        r_pend_valid, w_pend_valid_d;
    logic                        r_run;
    logic                        w_done, w_start, w_running, w_boundary, w_clear;
    logic [NUM_DIGITS-1:0]       r_anode, w_anode_d;
    bcd_t                        r_code, w_code_d;
    logic                        r_frame_start, w_frame_start_d;

    assign w_running  = enable & r_run;
    assign w_start    = enable & ~r_run;
    assign w_boundary = w_start |
                        (w_running & w_done & (r_state == DRIVE) & (r_idx == IdxLast));
    assign w_clear    = ~w_running | w_done;

    seven_seg_slot_timer #(
        .DRIVE_CYCLES (DRIVE_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk     (clk),
        .reset   (reset),
        .i_state (r_state),
        .i_clear (w_clear),
        .o_done  (w_done)
    );

    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        if (!enable) begin
            w_state_d = BLANK;
            w_idx_d   = '0;
        end else if (w_start) begin
            w_state_d = SlotFirst;
            w_idx_d   = '0;
        end else if (w_done) begin
            if (r_state == BLANK) begin
                w_state_d = DRIVE;
            end else begin
                w_state_d = SlotFirst;
                w_idx_d   = (r_idx == IdxLast) ? '0 : r_idx + IdxW'(1);
            end
        end
    end

    // A load landing on the frame boundary bypasses pending and shows this frame.
    always_comb begin
        w_active_d     = r_active;
        w_pending_d    = r_pending;
        w_pend_valid_d = r_pend_valid;
        if (w_boundary) begin
            if (load) begin
                w_active_d     = digitsIn;
                w_pend_valid_d = 1'b0;
            end else if (r_pend_valid) begin
                w_active_d     = r_pending;
                w_pend_valid_d = 1'b0;
            end
        end else if (load) begin
            w_pending_d    = digitsIn;
            w_pend_valid_d = 1'b1;
        end
    end

`ifdef SEVEN_SEG_LZ_BLANK_EN
    logic w_lz;

    always_comb begin
        w_lz    = 1'b1;
        w_shown = w_active_d;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            if (w_lz && (w_active_d[i] == 4'h0)) begin
                w_shown[i] = BLANK_CODE;
            end else begin
                w_lz = 1'b0;
            end
        end
    end
`else
    assign w_shown = w_active_d;
`endif

    // Outputs are registered from next-state so they line up with the FSM state.
    always_comb begin
        w_anode_d       = '1;
        w_code_d        = BLANK_CODE;
        w_frame_start_d = 1'b0;
        if (enable) begin
            w_code_d        = w_shown[w_idx_d];
            w_frame_start_d = w_boundary;
            if (w_state_d == DRIVE) begin
                w_anode_d = ~(NUM_DIGITS'(1) << w_idx_d);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= BLANK;
            r_idx         <= '0;
            r_active      <= {NUM_DIGITS{BLANK_CODE}};
            r_pending     <= {NUM_DIGITS{BLANK_CODE}};
            r_pend_valid  <= 1'b0;
            r_run         <= 1'b0;
            r_anode       <= '1;
            r_code        <= BLANK_CODE;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_idx         <= w_idx_d;
            r_active      <= w_active_d;
            r_pending     <= w_pending_d;
            r_pend_valid  <= w_pend_valid_d;
            r_run         <= enable;
            r_anode       <= w_anode_d;
            r_code        <= w_code_d;
            r_frame_start <= w_frame_start_d;
        end
    end

    assign anode      = r_anode;
    assign digitCode  = r_code;
    assign frameStart = r_frame_start;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: two instances (2-cycle gap and no gap) against a frame-phase model.
// Expectations follow SEVEN_SEG_LZ_BLANK_EN when it is defined.
module tb_seven_seg_scan_ctrl;

    localparam int N = 4;
    localparam int D = 8;
`ifdef SEVEN_SEG_LZ_BLANK_EN
    localparam logic [3:0] ZLEAD = 4'hF;
`else
    localparam logic [3:0] ZLEAD = 4'h0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [15:0] din;
    logic [3:0]  a_code, b_code, a_anode, b_anode;
    logic        a_fs, b_fs;

    int n_checks = 0;
    int n_errors = 0;
    int fs_cnt   = 0;
    int b_dark   = 0;

    always #5 clk = ~clk;

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DRIVE_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .digitsIn(din),
        .digitCode(a_code), .anode(a_anode), .frameStart(a_fs)
    );

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DRIVE_CYCLES(8), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .digitsIn(din),
        .digitCode(b_code), .anode(b_anode), .frameStart(b_fs)
    );

    task automatic chk(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    // Code shown for a digit position given the committed 16-bit value.
    function automatic logic [3:0] shown(input logic [15:0] act, input int slot);
        logic [3:0] d;
        d = act[4*slot +: 4];
`ifdef SEVEN_SEG_LZ_BLANK_EN
        if (slot != 0 && (act >> (4*slot)) == 16'h0) d = 4'hF;
`endif
        return d;
    endfunction

    // Model: position within the frame plus committed/pending values per instance.
    int          m_blk[2] = '{2, 0};
    bit          m_run[2];
    int          m_p[2];
    logic [15:0] m_act[2], m_pend[2];
    bit          m_pv[2];
    logic [3:0]  e_anode[2], e_code[2];
    logic        e_fs[2];

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            int sl, fl, slot, off, n_p;
            bit n_run, n_pv, bnd;
            logic [15:0] n_act, n_pend;
            logic [3:0] oh;
            sl = m_blk[k] + D;
            fl = N * sl;
            n_run = m_run[k]; n_p = m_p[k]; n_act = m_act[k]; n_pend = m_pend[k];
            n_pv = m_pv[k]; bnd = 1'b0;
            if (reset) begin
                n_run = 1'b0; n_p = 0; n_act = 16'hFFFF; n_pend = 16'hFFFF; n_pv = 1'b0;
            end else if (!enable) begin
                n_run = 1'b0; n_p = 0;
                if (load) begin n_pend = din; n_pv = 1'b1; end
            end else begin
                if (!m_run[k]) begin
                    n_run = 1'b1; n_p = 0; bnd = 1'b1;
                end else begin
                    n_p = (m_p[k] + 1) % fl;
                    bnd = (n_p == 0);
                end
                if (bnd) begin
                    if (load) begin n_act = din; n_pv = 1'b0; end
                    else if (m_pv[k]) begin n_act = m_pend[k]; n_pv = 1'b0; end
                end else if (load) begin
                    n_pend = din; n_pv = 1'b1;
                end
            end
            if (!n_run) begin
                e_anode[k] <= 4'hF; e_code[k] <= 4'hF; e_fs[k] <= 1'b0;
            end else begin
                slot = n_p / sl;
                off  = n_p % sl;
                oh   = 4'b0001 << slot;
                e_anode[k] <= (off < m_blk[k]) ? 4'hF : ~oh;
                e_code[k]  <= shown(n_act, slot);
                e_fs[k]    <= (n_p == 0);
            end
            m_run[k] <= n_run; m_p[k] <= n_p; m_act[k] <= n_act;
            m_pend[k] <= n_pend; m_pv[k] <= n_pv;
        end
    end

    always @(negedge clk) begin
        chk("a_anode", 32'(a_anode), 32'(e_anode[0]));
        chk("a_code", 32'(a_code), 32'(e_code[0]));
        chk("a_frame_start", 32'(a_fs), 32'(e_fs[0]));
        chk("b_anode", 32'(b_anode), 32'(e_anode[1]));
        chk("b_code", 32'(b_code), 32'(e_code[1]));
        chk("b_frame_start", 32'(b_fs), 32'(e_fs[1]));
    end

    task automatic nx();
        @(negedge clk);
        #1;
    endtask

    task automatic seek(input int n);
        repeat (n) nx();
    endtask

    task automatic lit(input string name, input logic [3:0] an, input logic [3:0] cd);
        chk({name, "_anode"}, 32'(a_anode), 32'(an));
        chk({name, "_code"}, 32'(a_code), 32'(cd));
    endtask

    logic [3:0] lit_an[4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [3:0] lit_cd[4] = '{4'h4, 4'h3, 4'h2, 4'h1};

    initial begin
        reset = 1'b1; enable = 1'b0; load = 1'b0; din = 16'h0;
        seek(3);
        lit("lit_reset", 4'hF, 4'hF);
        chk("lit_reset_fs", 32'(a_fs), 0);
        reset = 1'b0;
        nx();
        enable = 1'b1; load = 1'b1; din = 16'h1234;
        nx();
        load = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) nx();
            if (b_anode == 4'hF) b_dark++;
            if (a_fs) fs_cnt++;
            if (c == 0) chk("lit_first_fs", 32'(a_fs), 1);
            if (c % 10 < 2) chk("lit_gap_anode", 32'(a_anode), 32'(4'hF));
            else lit("lit_frame1", lit_an[c/10], lit_cd[c/10]);
        end
        chk("lit_fs_per_frame", fs_cnt, 1);
        chk("lit_b_never_dark", b_dark, 0);

        // Mid-frame load during digit 2.
        seek(26);
        load = 1'b1; din = 16'h5678;
        nx(); load = 1'b0;
        seek(9);  lit("lit_old_digit3", 4'b0111, 4'h1);
        seek(7);  lit("lit_new_digit0", 4'b1110, 4'h8);
        // Two loads in one frame: last wins.
        load = 1'b1; din = 16'h9999;
        nx(); load = 1'b0;
        seek(5);
        load = 1'b1; din = 16'h0702;
        nx(); load = 1'b0;
        seek(33); lit("lit_last_d0", 4'b1110, 4'h2);
        seek(20); lit("lit_last_d2", 4'b1011, 4'h7);
        seek(10); lit("lit_last_d3", 4'b0111, ZLEAD);
        // Load exactly on the wrap edge.
        seek(7);
        load = 1'b1; din = 16'h4321;
        nx(); load = 1'b0;
        chk("lit_wrap_fs", 32'(a_fs), 1);
        seek(2);  lit("lit_wrap_d0", 4'b1110, 4'h1);
        // Drop enable in digit 1 drive, load while dark.
        seek(13);
        enable = 1'b0;
        nx(); lit("lit_dark1", 4'hF, 4'hF);
        load = 1'b1; din = 16'h0050;
        nx(); load = 1'b0;
        lit("lit_dark2", 4'hF, 4'hF);
        seek(3); lit("lit_dark3", 4'hF, 4'hF);
        enable = 1'b1;
        nx(); chk("lit_reen_fs", 32'(a_fs), 1);
        chk("lit_reen_gap", 32'(a_anode), 32'(4'hF));
        seek(2);  lit("lit_0050_d0", 4'b1110, 4'h0);
        seek(10); lit("lit_0050_d1", 4'b1101, 4'h5);
        seek(10); lit("lit_0050_d2", 4'b1011, ZLEAD);
        seek(10); lit("lit_0050_d3", 4'b0111, ZLEAD);
        seek(1);
        load = 1'b1; din = 16'h0000;
        nx(); load = 1'b0;
        seek(8);  lit("lit_0000_d0", 4'b1110, 4'h0);
        seek(10); lit("lit_0000_d1", 4'b1101, ZLEAD);

        // Randomized traffic, including dark periods and mid-run resets.
        for (int i = 0; i < 3000; i++) begin
            nx();
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                nx();
                reset = 1'b0;
            end
            if ($urandom_range(0, 79) == 0) enable = ~enable;
            load = ($urandom_range(0, 29) == 0);
            for (int j = 0; j < 4; j++) begin
                din[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            end
        end
        nx();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
